// File: rtl/axi_lite_to_reg_split.sv
// AXI4-Lite to register-bus bridge splitting each wide access into narrow register beats.
// Optional per-beat timeout enabled by defining AXI_LITE_TO_REG_SPLIT_TIMEOUT_EN.
package axi_lite_to_reg_split_pkg;
  localparam int unsigned DEF_ADDR_WIDTH     = 32;
  localparam int unsigned DEF_AXI_DATA_WIDTH = 64;
  localparam int unsigned DEF_REG_DATA_WIDTH = 32;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]       aw_addr;
    logic                            aw_valid;
    logic [DEF_AXI_DATA_WIDTH-1:0]   w_data;
    logic [DEF_AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                            w_valid;
    logic                            b_ready;
    logic [DEF_ADDR_WIDTH-1:0]       ar_addr;
    logic                            ar_valid;
    logic                            r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic                          aw_ready;
    logic                          w_ready;
    logic [1:0]                    b_resp;
    logic                          b_valid;
    logic                          ar_ready;
    logic [DEF_AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                    r_resp;
    logic                          r_valid;
  } axi_lite_rsp_t;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]       addr;
    logic                            write;
    logic [DEF_REG_DATA_WIDTH-1:0]   wdata;
    logic [DEF_REG_DATA_WIDTH/8-1:0] wstrb;
    logic                            valid;
  } reg_req_t;

  typedef struct packed {
    logic [DEF_REG_DATA_WIDTH-1:0] rdata;
    logic                          error;
    logic                          ready;
  } reg_rsp_t;
endpackage

module axi_lite_to_reg_split #(
  parameter int unsigned ADDR_WIDTH     = axi_lite_to_reg_split_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned AXI_DATA_WIDTH = axi_lite_to_reg_split_pkg::DEF_AXI_DATA_WIDTH,
  parameter int unsigned REG_DATA_WIDTH = axi_lite_to_reg_split_pkg::DEF_REG_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter type axi_lite_req_t = axi_lite_to_reg_split_pkg::axi_lite_req_t,
  parameter type axi_lite_rsp_t = axi_lite_to_reg_split_pkg::axi_lite_rsp_t,
  parameter type reg_req_t      = axi_lite_to_reg_split_pkg::reg_req_t,
  parameter type reg_rsp_t      = axi_lite_to_reg_split_pkg::reg_rsp_t
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  axi_lite_req_t axi_lite_req_i,
  output axi_lite_rsp_t axi_lite_rsp_o,
  output reg_req_t      reg_req_o,
  input  reg_rsp_t      reg_rsp_i
);
  localparam int unsigned N  = AXI_DATA_WIDTH / REG_DATA_WIDTH;
  localparam int unsigned RB = REG_DATA_WIDTH / 8;
  localparam int unsigned AB = AXI_DATA_WIDTH / 8;
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, WBEAT, RBEAT, BRESP, RRESP} state_e;

  state_e                    state_q, state_d;
  logic [BW-1:0]             beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AB-1:0]             wstrb_q, wstrb_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      last_wr_q, last_wr_d;
  logic [BW:0]               nxt;
  logic                      wr_req, rd_req, grant_wr, grant_rd;

`ifdef AXI_LITE_TO_REG_SPLIT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // Returns {found, index} of the first beat at or after start with a non-zero strobe slice.
  function automatic logic [BW:0] first_beat(input logic [AB-1:0] strb, input int start);
    logic [BW:0] res;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (k >= start && |strb[k*RB +: RB]) res = {1'b1, BW'(k)};
    end
    return res;
  endfunction

  assign wr_req   = axi_lite_req_i.aw_valid && axi_lite_req_i.w_valid;
  assign rd_req   = axi_lite_req_i.ar_valid;
  assign grant_wr = wr_req && (!rd_req || !last_wr_q);
  assign grant_rd = rd_req && !grant_wr;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    last_wr_d = last_wr_q;
    nxt       = '0;
`ifdef AXI_LITE_TO_REG_SPLIT_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    axi_lite_rsp_o        = '0;
    axi_lite_rsp_o.b_resp = {err_q, 1'b0};
    axi_lite_rsp_o.r_resp = {err_q, 1'b0};
    axi_lite_rsp_o.r_data = rdata_q;
    reg_req_o             = '0;

    unique case (state_q)
      IDLE: begin
        if (rst_ni && grant_wr) begin
          axi_lite_rsp_o.aw_ready = 1'b1;
          axi_lite_rsp_o.w_ready  = 1'b1;
          addr_d    = axi_lite_req_i.aw_addr & ~ADDR_WIDTH'(AB - 1);
          wdata_d   = axi_lite_req_i.w_data;
          wstrb_d   = axi_lite_req_i.w_strb;
          err_d     = 1'b0;
          last_wr_d = 1'b1;
          nxt       = first_beat(axi_lite_req_i.w_strb, 0);
          beat_d    = nxt[BW-1:0];
          state_d   = nxt[BW] ? WBEAT : BRESP;
        end else if (rst_ni && grant_rd) begin
          axi_lite_rsp_o.ar_ready = 1'b1;
          addr_d    = axi_lite_req_i.ar_addr & ~ADDR_WIDTH'(AB - 1);
          rdata_d   = '0;
          beat_d    = '0;
          err_d     = 1'b0;
          last_wr_d = 1'b0;
          state_d   = RBEAT;
        end
      end
      WBEAT: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.write = 1'b1;
        reg_req_o.addr  = addr_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(RB);
        reg_req_o.wdata = wdata_q[beat_q*REG_DATA_WIDTH +: REG_DATA_WIDTH];
        reg_req_o.wstrb = wstrb_q[beat_q*RB +: RB];
        if (reg_rsp_i.ready) begin
          if (reg_rsp_i.error) begin
            err_d   = 1'b1;
            state_d = BRESP;
          end else begin
            nxt = first_beat(wstrb_q, int'(beat_q) + 1);
            if (nxt[BW]) beat_d = nxt[BW-1:0];
            else         state_d = BRESP;
          end
        end
      end
      RBEAT: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.addr  = addr_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(RB);
        if (reg_rsp_i.ready) begin
          if (reg_rsp_i.error) begin
            err_d   = 1'b1;
            state_d = RRESP;
          end else begin
            rdata_d[beat_q*REG_DATA_WIDTH +: REG_DATA_WIDTH] = reg_rsp_i.rdata;
            if (beat_q == BW'(N - 1)) state_d = RRESP;
            else                      beat_d  = beat_q + 1'b1;
          end
        end
      end
      BRESP: begin
        axi_lite_rsp_o.b_valid = 1'b1;
        if (axi_lite_req_i.b_ready) state_d = IDLE;
      end
      RRESP: begin
        axi_lite_rsp_o.r_valid = 1'b1;
        if (axi_lite_req_i.r_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef AXI_LITE_TO_REG_SPLIT_TIMEOUT_EN
    // A ready in the limit cycle wins over the timeout.
    if (state_q == WBEAT || state_q == RBEAT) begin
      if (reg_rsp_i.ready) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_d   = '0;
        err_d   = 1'b1;
        state_d = (state_q == WBEAT) ? BRESP : RRESP;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      last_wr_q <= 1'b0;
`ifdef AXI_LITE_TO_REG_SPLIT_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      last_wr_q <= last_wr_d;
`ifdef AXI_LITE_TO_REG_SPLIT_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end
endmodule
